// File: rtl/imm_narrow_pipe.sv
// Narrows a signed IN_W-bit value to a signed OUT_W-bit immediate through a two-stage valid/ready pipe.
// Values that do not fit are wrapped or saturated, and each overflowing output bumps a sticky flag and a counter.
module imm_narrow_pipe #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 17,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_ovf,
    input  logic             clr_sticky,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_v_q, s1_v_d;
    logic [IN_W-1:0]  s1_data_q, s1_data_d;
    logic             s1_sat_q, s1_sat_d;
    logic             s1_ovf_q, s1_ovf_d;
    logic             s2_v_q, s2_v_d;
    logic [OUT_W-1:0] out_imm_q, out_imm_d;
    logic             out_ovf_q, out_ovf_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             s1_ready;
    logic             s2_ready;
    logic             ovf_event;
    logic [IN_W-OUT_W:0] in_hi;
    logic             in_ovf;

    // The value fits only if every bit from the OUT_W sign position upward agrees.
    assign in_hi  = in_data[IN_W-1:OUT_W-1];
    assign in_ovf = ~(&in_hi | ~|in_hi);

    assign s2_ready = ~s2_v_q | out_ready;
    assign s1_ready = ~s1_v_q | s2_ready;
    assign in_ready = s1_ready;

    assign ovf_event = s2_v_q & out_ready & out_ovf_q;

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s1_sat_d  = s1_sat_q;
        s1_ovf_d  = s1_ovf_q;
        s2_v_d    = s2_v_q;
        out_imm_d = out_imm_q;
        out_ovf_d = out_ovf_q;
        sticky_d  = sticky_q;
        count_d   = count_q;

        if (s1_ready) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_sat_d  = in_sat;
                s1_ovf_d  = in_ovf;
            end
        end

        if (s2_ready) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                out_ovf_d = s1_ovf_q;
                if (s1_ovf_q && s1_sat_q) begin
                    out_imm_d = s1_data_q[IN_W-1] ? SAT_NEG : SAT_POS;
                end else begin
                    out_imm_d = s1_data_q[OUT_W-1:0];
                end
            end
        end

        // A clear coinciding with an event restarts the count at one.
        if (clr_sticky) begin
            sticky_d = ovf_event;
            count_d  = ovf_event ? CNT_ONE : '0;
        end else if (ovf_event) begin
            sticky_d = 1'b1;
            if (count_q != '1) begin
                count_d = count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_sat_q  <= 1'b0;
            s1_ovf_q  <= 1'b0;
            s2_v_q    <= 1'b0;
            out_imm_q <= '0;
            out_ovf_q <= 1'b0;
            sticky_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s1_sat_q  <= s1_sat_d;
            s1_ovf_q  <= s1_ovf_d;
            s2_v_q    <= s2_v_d;
            out_imm_q <= out_imm_d;
            out_ovf_q <= out_ovf_d;
            sticky_q  <= sticky_d;
            count_q   <= count_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign out_imm    = out_imm_q;
    assign out_ovf    = out_ovf_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

endmodule

// File: tb/tb_imm_narrow_pipe.sv
// Self-checking bench for imm_narrow_pipe: directed edge cases plus randomized traffic checked
// against a queue-based reference model that works on signed integer ranges.
module tb_imm_narrow_pipe;

    localparam int IN_W  = 32;
    localparam int OUT_W = 17;
    // A narrow counter makes the saturation case reachable in a few hundred cycles.
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic             out_ovf;
    logic             clr_sticky;
    logic             ovf_sticky;
    logic [CNT_W-1:0] ovf_count;

    imm_narrow_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sat     (in_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_ovf    (out_ovf),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [OUT_W-1:0] imm;
        logic             ovf;
        int               acc;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    m_count = 0;
    bit    m_sticky = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit ref_ovf(input logic [31:0] d);
        int sv;
        sv = int'(d);
        return (sv > 65535) || (sv < -65536);
    endfunction

    function automatic logic [OUT_W-1:0] ref_imm(input logic [31:0] d, input logic sat);
        int sv;
        sv = int'(d);
        if (sat && sv > 65535)  return 17'h0FFFF;
        if (sat && sv < -65536) return 17'h10000;
        return d[OUT_W-1:0];
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sat     = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        q.delete();
        m_count  = 0;
        m_sticky = 1'b0;
        cyc++;
    endtask

    // One clock: check registered state, drive inputs, check outputs, advance the model.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic sat,
                         input logic ordy, input logic clr);
        bit    exp_ov;
        bit    exp_ir;
        bit    evt;
        item_t it;
        @(negedge clock);
        check_val("ovf_count", 32'(ovf_count), 32'(m_count));
        check_val("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
        reset_n    = 1'b1;
        in_valid   = iv;
        in_data    = d;
        in_sat     = sat;
        out_ready  = ordy;
        clr_sticky = clr;
        #1;
        exp_ir = (q.size() < 2) || ordy;
        exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
        check_val("in_ready", 32'(in_ready), 32'(exp_ir));
        check_val("out_valid", 32'(out_valid), 32'(exp_ov));
        evt = 1'b0;
        if (exp_ov) begin
            check_val("out_imm", 32'(out_imm), 32'(q[0].imm));
            check_val("out_ovf", 32'(out_ovf), 32'(q[0].ovf));
            if (ordy) begin
                evt = q[0].ovf;
                void'(q.pop_front());
            end
        end
        if (clr) begin
            m_sticky = evt;
            m_count  = evt ? 1 : 0;
        end else if (evt) begin
            m_sticky = 1'b1;
            if (m_count < CNT_MAX) m_count++;
        end
        if (iv && exp_ir) begin
            it.imm = ref_imm(d, sat);
            it.ovf = ref_ovf(d);
            it.acc = cyc;
            q.push_back(it);
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, ordy, 1'b0);
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] edges [8];
        edges = '{32'h0000FFFF, 32'hFFFF0000, 32'h00010000, 32'hFFFEFFFF,
                  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};
        case ($urandom_range(0, 2))
            0:       return edges[$urandom_range(0, 7)];
            1:       return 32'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] edge4 [4];

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sat     = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        edge4 = '{32'h0000FFFF, 32'hFFFF0000, 32'h00010000, 32'hFFFEFFFF};

        apply_reset();
        apply_reset();
        idle(2, 1'b0);

        // Small in-range values, sign preserved.
        cycle(1'b1, 32'h00000005, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Range edges, saturating then wrapping.
        for (int i = 0; i < 4; i++) cycle(1'b1, edge4[i], 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, edge4[i], 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Back-pressure: downstream stalls for five cycles while inputs keep coming.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h00010000 + 32'(i), i[0], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h00000100 + 32'(i), 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Clear landing on an overflowing output transfer.
        cycle(1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);

        // Drive the counter into saturation and past it.
        for (int i = 0; i < CNT_MAX + 6; i++) cycle(1'b1, 32'h40000000 ^ 32'(i), 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Reset with two items in flight drops them.
        cycle(1'b1, 32'h00012345, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFF00000, 1'b1, 1'b0, 1'b0);
        apply_reset();
        idle(4, 1'b1);

        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_data(), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
        end
        idle(4, 1'b1);
        check_val("drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
